// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: decides when the irrigation pump runs from soil-moisture
// samples. Hysteresis between DRY_TH and WET_TH, bounded watering time, a soak
// wait after every run and a lockout after MAX_TIMEOUTS consecutive timeouts.
// Optional macro SENSOR_WATCHDOG_EN adds a lost-sensor watchdog (SENSOR_TO_S).
module irrigation_scheduler #(
    parameter int CLK_HZ       = 50000000,
    parameter int MOIST_W      = 10,
    parameter int DRY_TH       = 400,
    parameter int WET_TH       = 600,
    parameter int WATER_MAX_S  = 6,
    parameter int SOAK_S       = 5,
    parameter int MAX_TIMEOUTS = 3
`ifdef SENSOR_WATCHDOG_EN
    ,
    parameter int SENSOR_TO_S  = 10
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [MOIST_W-1:0] moisture,
    input  logic               manual_req,
    input  logic               fault_clr,
    output logic               pump_en,
    output logic [1:0]         state,
    output logic               fault,
    output logic [7:0]         run_count
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WATER = 2'b01,
        ST_SOAK  = 2'b10,
        ST_LOCK  = 2'b11
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          pump_en_r;
    logic          fault_r;
    logic [7:0]    run_count_r;
    logic [7:0]    to_cnt_r;
    logic [7:0]    to_next_s;
    logic [7:0]    to_inc_s;
    logic          run_inc_s;
    logic [PW-1:0] presc_r;
    logic [7:0]    sec_r;
    logic          sec_tick_s;
    logic          entry_s;
    logic          idle_entry_s;
    logic          dry_s;
    logic          wet_s;
    logic          water_done_s;
    logic          soak_done_s;
    logic          wd_expire_s;

    assign sec_tick_s   = (presc_r == PW'(CLK_HZ - 1));
    assign water_done_s = sec_tick_s && (sec_r == 8'(WATER_MAX_S - 1));
    assign soak_done_s  = sec_tick_s && (sec_r == 8'(SOAK_S - 1));
    assign dry_s        = sample_valid && (moisture < MOIST_W'(DRY_TH));
    assign wet_s        = sample_valid && (moisture >= MOIST_W'(WET_TH));
    assign to_inc_s     = to_cnt_r + 8'd1;
    assign entry_s      = (state_next_s != state_r);
    assign idle_entry_s = entry_s && (state_next_s == ST_IDLE);

`ifdef SENSOR_WATCHDOG_EN
    logic [PW-1:0] wd_presc_r;
    logic [7:0]    wd_sec_r;
    logic          wd_tick_s;
    logic          wd_active_s;

    assign wd_tick_s   = (wd_presc_r == PW'(CLK_HZ - 1));
    assign wd_active_s = (state_r == ST_IDLE) || (state_r == ST_WATER);
    // A fresh sample this cycle rescues the sensor even on the expiry cycle.
    assign wd_expire_s = wd_active_s && wd_tick_s && !sample_valid &&
                         (wd_sec_r == 8'(SENSOR_TO_S - 1));

    // Watchdog: whole seconds since the last sample, running only in IDLE/WATER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_presc_r <= '0;
            wd_sec_r   <= 8'd0;
        end else if (sample_valid || idle_entry_s) begin
            wd_presc_r <= '0;
            wd_sec_r   <= 8'd0;
        end else if (wd_active_s) begin
            if (wd_tick_s) begin
                wd_presc_r <= '0;
                wd_sec_r   <= wd_sec_r + 8'd1;
            end else begin
                wd_presc_r <= wd_presc_r + PW'(1);
            end
        end else begin
            wd_presc_r <= wd_presc_r;
            wd_sec_r   <= wd_sec_r;
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next-state, timeout-counter and run-completion decisions.
    always_comb begin
        state_next_s = state_r;
        to_next_s    = to_cnt_r;
        run_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wd_expire_s) begin
                    state_next_s = ST_LOCK;
                end else if (dry_s || manual_req) begin
                    state_next_s = ST_WATER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WATER: begin
                if (wd_expire_s) begin
                    state_next_s = ST_LOCK;
                end else if (wet_s) begin
                    state_next_s = ST_SOAK;
                    to_next_s    = 8'd0;
                    run_inc_s    = 1'b1;
                end else if (water_done_s) begin
                    to_next_s    = to_inc_s;
                    run_inc_s    = 1'b1;
                    if (to_inc_s == 8'(MAX_TIMEOUTS)) begin
                        state_next_s = ST_LOCK;
                    end else begin
                        state_next_s = ST_SOAK;
                    end
                end else begin
                    state_next_s = ST_WATER;
                end
            end
            ST_SOAK: begin
                if (soak_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SOAK;
                end
            end
            ST_LOCK: begin
                if (fault_clr) begin
                    state_next_s = ST_IDLE;
                    to_next_s    = 8'd0;
                end else begin
                    state_next_s = ST_LOCK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                to_next_s    = 8'd0;
            end
        endcase
    end

    // State, registered outputs, timeout counter and saturating run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pump_en_r   <= 1'b0;
            fault_r     <= 1'b0;
            to_cnt_r    <= 8'd0;
            run_count_r <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            pump_en_r <= (state_next_s == ST_WATER);
            fault_r   <= (state_next_s == ST_LOCK);
            to_cnt_r  <= to_next_s;
            if (run_inc_s && (run_count_r != 8'hFF)) begin
                run_count_r <= run_count_r + 8'd1;
            end else begin
                run_count_r <= run_count_r;
            end
        end
    end

    // Prescaler and second counter restart on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            sec_r   <= 8'd0;
        end else if (entry_s) begin
            presc_r <= '0;
            sec_r   <= 8'd0;
        end else if (sec_tick_s) begin
            presc_r <= '0;
            sec_r   <= sec_r + 8'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign pump_en   = pump_en_r;
    assign state     = state_r;
    assign fault     = fault_r;
    assign run_count = run_count_r;

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
Decision stage directly upstream of the LED/status indicator stage. Consumes soil-moisture samples and decides when the pump runs.
- Drives pump_en and state, which the indicator stage consumes to show motor on/off.
- Enforces hysteresis, a maximum watering time, a soak wait and a fault lockout after repeated timeouts.

Parameters:
CLK_HZ, 50000000, clock cycles per second tick
MOIST_W, 10, moisture sample width
DRY_TH, 400, moisture < DRY_TH means dry
WET_TH, 600, moisture >= WET_TH means wet; must be > DRY_TH
WATER_MAX_S, 6, maximum watering seconds per run
SOAK_S, 5, post-watering wait seconds
MAX_TIMEOUTS, 3, consecutive timeout runs before lockout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe; moisture valid this cycle
moisture  in  MOIST_W  unsigned moisture sample
manual_req  in  1  one-cycle pulse requesting a watering run
fault_clr  in  1  one-cycle pulse that clears lockout
pump_en  out  1  motor enable
state  out  2  00 IDLE, 01 WATER, 10 SOAK, 11 LOCKOUT
fault  out  1  high in LOCKOUT
run_count  out  8  completed runs, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE, pump_en=0, fault=0, run_count=0. Prescaler, second counter and timeout counter are all 0.
- All outputs are registered. pump_en=1 exactly when state=WATER. fault=1 exactly when state=LOCKOUT.
- Prescaler:
  - Counts 0..CLK_HZ-1 and emits a one-cycle sec_tick on wrap.
  - Prescaler and second counter clear on every state entry, so a timed state lasts exactly N*CLK_HZ cycles.
- IDLE:
  - Goes to WATER on sample_valid with moisture<DRY_TH, or on manual_req. A simultaneous dry sample and manual_req is a single entry.
  - Transition takes effect at the next edge; pump_en rises 1 cycle after the triggering strobe.
- WATER:
  - Wet end: sample_valid with moisture>=WET_TH goes to SOAK. The timeout counter clears and run_count increments.
  - Timeout end: the second counter reaching WATER_MAX_S goes to SOAK. The timeout counter increments and run_count increments.
  - If the incremented timeout counter equals MAX_TIMEOUTS, go to LOCKOUT instead of SOAK.
  - A wet sample on the same cycle as the timeout: wet end wins.
  - manual_req is ignored.
- SOAK:
  - After SOAK_S seconds, go to IDLE.
  - Samples and manual_req are ignored.
- LOCKOUT:
  - pump_en=0, fault=1. Samples and manual_req are ignored.
  - fault_clr goes to IDLE and clears the timeout counter. run_count is kept.
- fault_clr has no effect outside LOCKOUT.
- run_count saturates at 255.
- Moisture samples between DRY_TH and WET_TH-1 cause no transition (hysteresis band).
- Reset asserted mid-run: pump_en drops immediately (async) and the block restarts in IDLE.

Optional Feature:
SENSOR_WATCHDOG_EN
- Defined:
  - Adds parameter SENSOR_TO_S (default 10).
  - A watchdog counts seconds since the last sample_valid, in IDLE and WATER only.
  - Reaching SENSOR_TO_S goes to LOCKOUT regardless of the timeout counter.
  - The watchdog clears on every sample_valid and on entry to IDLE.
- Undefined: no watchdog; sample loss never causes a fault.

Test Plan:
1. CLK_HZ=10, release reset, no stimulus -> state=00, pump_en=0, fault=0, run_count=0 for 100 cycles.
2. Sample moisture=300 at cycle 5, then moisture=650 at cycle 30 -> pump_en=1 on cycles 6..30, state=10 at cycle 31, state=00 at cycle 81, run_count=1.
3. Sample 300, then only samples of 500 -> pump_en high exactly 60 cycles, SOAK 50 cycles. Third consecutive run -> state=11, fault=1, pump_en=0. fault_clr -> state=00 next cycle, run_count=3.
4. In WATER, wet sample on the same cycle the second counter hits WATER_MAX_S -> SOAK via wet end; timeout counter 0; two further timeouts do not lock out.
5. manual_req in IDLE -> WATER. manual_req during WATER and SOAK -> no effect. Assert rst_n=0 mid-WATER -> pump_en=0 same cycle, state=00 after release.
6. With SENSOR_WATCHDOG_EN, SENSOR_TO_S=3, no sample_valid for 30 cycles in IDLE -> state=11 at cycle 30. Without the macro -> stays 00.
